// File: rtl/tictactoe_game_ctrl.sv
// TicTacToe game-state controller: debounced left/right buttons move a
// cursor and place alternating X/O marks; reports win or draw.
// Ports: clk, reset (async, active-low), left, right (raw buttons);
//   board[17:0] (2 bits per cell, row-major), cursor[3:0], turn,
//   winner[1:0] (01 X, 10 O, 11 draw), game_over.
module tictactoe_game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  output logic [17:0] board,
  output logic [3:0]  cursor,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        game_over
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  // Button front end, index 0 = left, index 1 = right.
  logic [1:0]  btn_raw;
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  deb_q, deb_d;
  logic [1:0]  deb_prev_q;
  logic [1:0]  pls_q, pls_d;
  logic [23:0] cnt_q [2];
  logic [23:0] cnt_d [2];

  assign btn_raw = {right, left};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 24'd1;
      end
    end
    pls_d = deb_q & ~deb_prev_q;
  end

  logic l_pls, r_pls;
  assign l_pls = pls_q[0];
  assign r_pls = pls_q[1];

  // Game state
  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  cursor_q, cursor_d;
  logic        turn_q, turn_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_over_q, game_over_d;
  logic [3:0]  moves_q, moves_d;

  logic [4:0]  idx;
  logic [1:0]  mark;
  logic [1:0]  cur_cell;
  logic [8:0]  m;
  logic        win;

  assign idx      = {cursor_q, 1'b0};
  assign mark     = turn_q ? 2'b10 : 2'b01;
  assign cur_cell = board_q[idx +: 2];

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      m[i] = (board_q[2*i +: 2] == mark);
    end
  end

  assign win = (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) |
               (m[6] & m[7] & m[8]) | (m[0] & m[3] & m[6]) |
               (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    cursor_d    = cursor_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    moves_d     = moves_q;
    unique case (state_q)
      PLAY: begin
        // A right pulse always masks a simultaneous left pulse.
        if (r_pls) begin
          if (cur_cell == 2'b00) begin
            board_d[idx +: 2] = mark;
            moves_d = moves_q + 4'd1;
            state_d = CHECK;
          end
        end else if (l_pls) begin
          cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
        end
      end
      CHECK: begin
        if (win) begin
          winner_d    = mark;
          game_over_d = 1'b1;
          state_d     = OVER;
        end else if (moves_q == 4'd9) begin
          winner_d    = 2'b11;
          game_over_d = 1'b1;
          state_d     = OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = PLAY;
        end
      end
      OVER: begin
        if (r_pls) begin
          board_d     = '0;
          cursor_d    = '0;
          turn_d      = 1'b0;
          winner_d    = 2'b00;
          game_over_d = 1'b0;
          moves_d     = '0;
          state_d     = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      pls_q       <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      state_q     <= PLAY;
      board_q     <= '0;
      cursor_q    <= '0;
      turn_q      <= 1'b0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      moves_q     <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      pls_q       <= pls_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      state_q     <= state_d;
      board_q     <= board_d;
      cursor_q    <= cursor_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      moves_q     <= moves_d;
    end
  end

  assign board     = board_q;
  assign cursor    = cursor_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Bench for tictactoe_game_ctrl with DEBOUNCE_CYCLES=4.
// Table of button actions with settled expected state, plus timing cases.
module tb_tictactoe_game_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        left = 1'b0;
  logic        right = 1'b0;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic        turn;
  logic [1:0]  winner;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;

  tictactoe_game_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .left      (left),
    .right     (right),
    .board     (board),
    .cursor    (cursor),
    .turn      (turn),
    .winner    (winner),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nl;
    bit          rp;
    bit          both;
    logic [17:0] b;
    logic [3:0]  c;
    logic        t;
    logic [1:0]  w;
    logic        g;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [25:0] pk(input logic [17:0] b,
                                     input logic [3:0] c,
                                     input logic t,
                                     input logic [1:0] w,
                                     input logic g);
    return {b, c, t, w, g};
  endfunction

  function automatic logic [25:0] st();
    return {board, cursor, turn, winner, game_over};
  endfunction

  task automatic chk(input string nm, input logic [25:0] got,
                     input logic [25:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got board/cur/turn/win/go=%h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic add(input string nm, input int nl, input bit rp,
                     input bit both, input logic [17:0] b,
                     input logic [3:0] c, input logic t,
                     input logic [1:0] w, input logic g);
    vec_t v;
    v.name = nm; v.nl = nl; v.rp = rp; v.both = both;
    v.b = b; v.c = c; v.t = t; v.w = w; v.g = g;
    vecs.push_back(v);
  endtask

  task automatic press(input bit l, input bit r);
    @(negedge clk);
    left = l;
    right = r;
    repeat (20) @(negedge clk);
    left = 1'b0;
    right = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_vecs(input int from, input int to);
    for (int i = from; i < to; i++) begin
      repeat (vecs[i].nl) press(1'b1, 1'b0);
      if (vecs[i].both) press(1'b1, 1'b1);
      else if (vecs[i].rp) press(1'b0, 1'b1);
      chk(vecs[i].name, st(),
          pk(vecs[i].b, vecs[i].c, vecs[i].t, vecs[i].w, vecs[i].g));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  int split_a;

  initial begin
    // Phase A: cursor wrap and first four moves of X row win.
    for (int i = 1; i <= 9; i++) begin
      add($sformatf("wrap%0d", i), 1, 0, 0, 18'h0, 4'(i % 9), 0, 2'b00, 0);
    end
    add("x0", 0, 1, 0, 18'h00001, 4'd0, 1, 2'b00, 0);
    add("o3", 3, 1, 0, 18'h00081, 4'd3, 0, 2'b00, 0);
    add("x1", 7, 1, 0, 18'h00085, 4'd1, 1, 2'b00, 0);
    add("o4", 3, 1, 0, 18'h00285, 4'd4, 0, 2'b00, 0);
    add("to2", 7, 0, 0, 18'h00285, 4'd2, 0, 2'b00, 0);
    split_a = vecs.size();
    // Phase B: OVER behaviour, draw, occupied and simultaneous presses.
    add("over_left", 1, 0, 0, 18'h00295, 4'd2, 0, 2'b01, 1);
    add("over_clear", 0, 1, 0, 18'h0, 4'd0, 0, 2'b00, 0);
    add("d_x0", 0, 1, 0, 18'h00001, 4'd0, 1, 2'b00, 0);
    add("d_o1", 1, 1, 0, 18'h00009, 4'd1, 0, 2'b00, 0);
    add("d_x2", 1, 1, 0, 18'h00019, 4'd2, 1, 2'b00, 0);
    add("d_o4", 2, 1, 0, 18'h00219, 4'd4, 0, 2'b00, 0);
    add("d_x3", 8, 1, 0, 18'h00259, 4'd3, 1, 2'b00, 0);
    add("d_o5", 2, 1, 0, 18'h00A59, 4'd5, 0, 2'b00, 0);
    add("d_x7", 2, 1, 0, 18'h04A59, 4'd7, 1, 2'b00, 0);
    add("d_o6", 8, 1, 0, 18'h06A59, 4'd6, 0, 2'b00, 0);
    add("d_x8", 2, 1, 0, 18'h16A59, 4'd8, 0, 2'b11, 1);
    add("d_clear", 0, 1, 0, 18'h0, 4'd0, 0, 2'b00, 0);
    add("oc_x0", 0, 1, 0, 18'h00001, 4'd0, 1, 2'b00, 0);
    add("oc_occ", 0, 1, 0, 18'h00001, 4'd0, 1, 2'b00, 0);
    add("both", 1, 0, 1, 18'h00009, 4'd1, 0, 2'b00, 0);
    add("m3", 1, 1, 0, 18'h00019, 4'd2, 1, 2'b00, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk("reset_state", st(), pk(18'h0, 4'd0, 0, 2'b00, 0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Bounce: 3-cycle glitch is rejected, then one clean hold.
    right = 1'b1;
    repeat (3) @(negedge clk);
    right = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_glitch", st(), pk(18'h0, 4'd0, 0, 2'b00, 0));
    right = 1'b1;
    repeat (20) @(negedge clk);
    right = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce_hold", st(), pk(18'h00001, 4'd0, 1, 2'b00, 0));

    do_reset();
    run_vecs(0, split_a);

    // Final X at cell 2: board at edge 8, winner at edge 9.
    @(posedge clk);
    #1 right = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk("win_e7", st(), pk(18'h00285, 4'd2, 0, 2'b00, 0));
    @(posedge clk);
    #1 chk("win_e8", st(), pk(18'h00295, 4'd2, 0, 2'b00, 0));
    @(posedge clk);
    #1 chk("win_e9", st(), pk(18'h00295, 4'd2, 0, 2'b01, 1));
    repeat (10) @(negedge clk);
    right = 1'b0;
    repeat (12) @(negedge clk);
    chk("win_held", st(), pk(18'h00295, 4'd2, 0, 2'b01, 1));

    run_vecs(split_a, vecs.size());

    // Reset mid-game while right is mid-debounce.
    @(posedge clk);
    #1 right = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("rst_async", st(), pk(18'h0, 4'd0, 0, 2'b00, 0));
    right = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 right = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk("rst_e7", st(), pk(18'h0, 4'd0, 0, 2'b00, 0));
    @(posedge clk);
    #1 chk("rst_e8", st(), pk(18'h00001, 4'd0, 0, 2'b00, 0));
    @(posedge clk);
    #1 chk("rst_e9", st(), pk(18'h00001, 4'd0, 1, 2'b00, 0));
    right = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
